// File: rtl/mul_err_pkg.sv
// mul_err_pkg: shared types, widths and LFSR helper for the multiplier error sweep
package mul_err_pkg;
    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CAPTURE, DONE} state_e;
    localparam int OP_W   = 8;
    localparam int P_W    = 16;
    localparam int ED_W   = 17;
    localparam int SUM_W  = 32;
    localparam int SSUM_W = 34;
    localparam int CNT_W  = 17;
    localparam logic [P_W-1:0] LFSR_TAPS = 16'h002D;
    function automatic logic [P_W-1:0] lfsr_step(input logic [P_W-1:0] s);
        return {^(s & LFSR_TAPS), s[P_W-1:1]};
    endfunction
endpackage

// File: rtl/mul_err_accum.sv
// mul_err_accum: compares a captured product with the exact one and accumulates error statistics
module mul_err_accum
    import mul_err_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    input  logic [P_W-1:0]    o,
    output logic [CNT_W-1:0]  samples,
    output logic [CNT_W-1:0]  err_count,
    output logic [SUM_W-1:0]  sum_abs_ed,
    output logic [SSUM_W-1:0] sum_ed,
    output logic [P_W-1:0]    max_ed
);
    logic [P_W-1:0]    exact;
    logic [ED_W-1:0]   ed, abs_full;
    logic [P_W-1:0]    abs_ed;
    logic [CNT_W-1:0]  samples_q, samples_d, err_count_q, err_count_d;
    logic [SUM_W-1:0]  sum_abs_ed_q, sum_abs_ed_d;
    logic [SSUM_W-1:0] sum_ed_q, sum_ed_d;
    logic [P_W-1:0]    max_ed_q, max_ed_d;

    always_comb begin
        exact        = {8'd0, a} * {8'd0, b};
        ed           = {1'b0, exact} - {1'b0, o};
        abs_full     = ed[ED_W-1] ? -ed : ed;
        abs_ed       = abs_full[P_W-1:0];
        samples_d    = samples_q;
        err_count_d  = err_count_q;
        sum_abs_ed_d = sum_abs_ed_q;
        sum_ed_d     = sum_ed_q;
        max_ed_d     = max_ed_q;
        if (clr) begin
            samples_d    = '0;
            err_count_d  = '0;
            sum_abs_ed_d = '0;
            sum_ed_d     = '0;
            max_ed_d     = '0;
        end else if (en) begin
            samples_d    = samples_q + 1'b1;
            err_count_d  = err_count_q + CNT_W'(ed != '0);
            sum_abs_ed_d = sum_abs_ed_q + SUM_W'(abs_ed);
            sum_ed_d     = sum_ed_q + {{(SSUM_W-ED_W){ed[ED_W-1]}}, ed};
            max_ed_d     = (abs_ed > max_ed_q) ? abs_ed : max_ed_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samples_q    <= '0;
            err_count_q  <= '0;
            sum_abs_ed_q <= '0;
            sum_ed_q     <= '0;
            max_ed_q     <= '0;
        end else begin
            samples_q    <= samples_d;
            err_count_q  <= err_count_d;
            sum_abs_ed_q <= sum_abs_ed_d;
            sum_ed_q     <= sum_ed_d;
            max_ed_q     <= max_ed_d;
        end
    end

    assign samples    = samples_q;
    assign err_count  = err_count_q;
    assign sum_abs_ed = sum_abs_ed_q;
    assign sum_ed     = sum_ed_q;
    assign max_ed     = max_ed_q;
endmodule

// File: rtl/mul8_err_sweep_ctrl.sv
// mul8_err_sweep_ctrl: sweeps operand pairs through an 8x8 approximate multiplier and gathers error statistics
module mul8_err_sweep_ctrl
    import mul_err_pkg::*;
#(
    parameter int              SETTLE_CYCLES = 2,
    parameter logic [P_W-1:0]  LFSR_SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [P_W-1:0]    num_samples,
    input  logic              abort,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [P_W-1:0]    mul_o,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  samples,
    output logic [CNT_W-1:0]  err_count,
    output logic [SUM_W-1:0]  sum_abs_ed,
    output logic [SSUM_W-1:0] sum_ed,
    output logic [P_W-1:0]    max_ed
);
    localparam logic [P_W-1:0] SEED = (LFSR_SEED == '0) ? 16'h0001 : LFSR_SEED;
    localparam logic [3:0]     S    = 4'(SETTLE_CYCLES);

    state_e           state_q, state_d;
    logic [3:0]       sc_q, sc_d;
    logic [P_W-1:0]   lfsr_q, lfsr_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
    logic             mode_q, mode_d, abort_q, abort_d, busy_q, busy_d, done_q, done_d;
    logic             clr, en, last;

    always_comb begin
        state_d  = state_q;
        sc_d     = sc_q;
        lfsr_d   = lfsr_q;
        target_d = target_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        abort_d  = abort_q;
        busy_d   = busy_q;
        done_d   = done_q;
        clr      = 1'b0;
        en       = 1'b0;
        last     = abort_q || abort || (samples + 1'b1 == target_q);
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d  = DRIVE;
                clr      = 1'b1;
                mode_d   = mode;
                target_d = (mode && num_samples != '0) ? {1'b0, num_samples} : 17'h10000;
                abort_d  = 1'b0;
                busy_d   = 1'b1;
                done_d   = 1'b0;
            end
            DRIVE: begin
                {a_d, b_d} = mode_q ? lfsr_q : samples[P_W-1:0];
                state_d    = (S == 4'd0) ? CAPTURE : SETTLE;
                sc_d       = S - 4'd1;
                abort_d    = abort_q || abort;
            end
            SETTLE: begin
                state_d = (sc_q == 4'd0) ? CAPTURE : SETTLE;
                sc_d    = sc_q - 4'd1;
                abort_d = abort_q || abort;
            end
            CAPTURE: begin
                en      = 1'b1;
                lfsr_d  = mode_q ? lfsr_step(lfsr_q) : lfsr_q;
                state_d = last ? DONE : DRIVE;
                busy_d  = !last;
                done_d  = last;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sc_q     <= '0;
            lfsr_q   <= SEED;
            target_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            abort_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sc_q     <= sc_d;
            lfsr_q   <= lfsr_d;
            target_q <= target_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            abort_q  <= abort_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    mul_err_accum u_accum (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .en         (en),
        .a          (a_q),
        .b          (b_q),
        .o          (mul_o),
        .samples    (samples),
        .err_count  (err_count),
        .sum_abs_ed (sum_abs_ed),
        .sum_ed     (sum_ed),
        .max_ed     (max_ed)
    );

    assign mul_a = a_q;
    assign mul_b = b_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule

// File: tb/tb_mul8_err_sweep_ctrl.sv
// tb_mul8_err_sweep_ctrl: random and directed sweeps checked against a behavioural model of the sequencer
module tb_mul8_err_sweep_ctrl;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst, start, mode, abort;
    logic [15:0] num_samples, mul_o;
    logic [7:0]  mul_a, mul_b;
    logic        busy, done;
    logic [16:0] samples, err_count;
    logic [31:0] sum_abs_ed;
    logic [33:0] sum_ed;
    logic [15:0] max_ed;
    int          stub_sel;
    int          n_cmp = 0, n_bad = 0;
    bit          chk_en = 1'b0;

    mul8_err_sweep_ctrl #(.SETTLE_CYCLES(S), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .num_samples(num_samples), .abort(abort),
        .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o), .busy(busy), .done(done), .samples(samples),
        .err_count(err_count), .sum_abs_ed(sum_abs_ed), .sum_ed(sum_ed), .max_ed(max_ed)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] stub_f(input int s, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(int'(a) * int'(b));
        case (s)
            1: return p & 16'hFFFE;
            2: return 16'h0000;
            3: return 16'hFFFF;
            4: return p ^ ({a, b} & 16'h0303);
            default: return p;
        endcase
    endfunction

    always_comb mul_o = stub_f(stub_sel, mul_a, mul_b);

    // Behavioural model: sample k occupies S+2 cycles, position 0 drives, last position captures.
    bit          m_busy, m_done, m_mode, m_ab;
    int          m_pos, m_k, m_tgt;
    logic [7:0]  m_a, m_b;
    logic [15:0] m_lfsr;
    longint      m_err, m_sabs, m_sed, m_max;

    always @(posedge clk) begin
        int ed;
        if (rst) begin
            m_busy = 0; m_done = 0; m_mode = 0; m_ab = 0; m_pos = 0; m_k = 0; m_tgt = 0;
            m_a = 0; m_b = 0; m_lfsr = 16'hACE1; m_err = 0; m_sabs = 0; m_sed = 0; m_max = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_done = 0; m_pos = 0; m_k = 0; m_ab = 0; m_mode = mode;
                m_tgt = (mode && num_samples != 0) ? int'(num_samples) : 65536;
                m_err = 0; m_sabs = 0; m_sed = 0; m_max = 0;
            end
        end else begin
            if (abort) m_ab = 1;
            if (m_pos == 0) {m_a, m_b} = m_mode ? m_lfsr : 16'(m_k);
            if (m_pos == S + 1) begin
                ed = int'(m_a) * int'(m_b) - int'(stub_f(stub_sel, m_a, m_b));
                if (ed != 0) m_err++;
                m_sabs += (ed < 0) ? -ed : ed;
                m_sed  += ed;
                if (((ed < 0) ? -ed : ed) > m_max) m_max = (ed < 0) ? -ed : ed;
                m_k++;
                if (m_mode) m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
                m_pos = 0;
                if (m_ab || m_k == m_tgt) begin m_busy = 0; m_done = 1; end
            end else m_pos++;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sed_val();
        logic signed [33:0] t;
        t = sum_ed;
        return longint'(t);
    endfunction

    always @(negedge clk) if (chk_en) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("mul_a", mul_a, m_a);
        chk("mul_b", mul_b, m_b);
        chk("samples", samples, m_k);
        chk("err_count", err_count, m_err);
        chk("sum_abs_ed", sum_abs_ed, m_sabs);
        chk("sum_ed", sed_val(), m_sed);
        chk("max_ed", max_ed, m_max);
    end

    task automatic run(input bit md, input int n, input int st, input int ab_at, input int bs_at,
                       input int rst_at, output int cyc);
        int budget, i;
        stub_sel = st; mode = md; num_samples = 16'(n);
        budget = ((md && n != 0) ? n + 2 : 70000) * (S + 2) + 10;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (i = 0; i < budget; i++) begin
            if (done) break;
            if (rst_at >= 0 && m_k == rst_at) begin
                rst = 1; @(negedge clk); rst = 0; cyc = i; return;
            end
            abort = (ab_at >= 0 && m_busy && m_k == ab_at && m_pos == 1);
            start = (bs_at >= 0 && m_busy && m_k == bs_at && m_pos == 1);
            mode = 1'($urandom);
            num_samples = 16'($urandom);
            @(negedge clk);
        end
        abort = 0; start = 0;
        cyc = i;
        if (i == budget) chk("done_within_budget", done, 1);
    endtask

    task automatic pin_lfsr_run();
        int cyc;
        run(1, 4, 3, -1, -1, -1, cyc);
        chk("rand4_cycles", cyc, 16);
        chk("rand4_samples", samples, 4);
        chk("rand4_err", err_count, 4);
        chk("rand4_sum_ed", sed_val(), -190972);
        chk("rand4_sum_abs", sum_abs_ed, 190972);
        chk("rand4_max", max_ed, 55959);
        chk("rand4_last_a", mul_a, 8'h55);
        chk("rand4_last_b", mul_b, 8'h9C);
    endtask

    initial begin
        int cyc, n;
        rst = 1; start = 0; abort = 0; mode = 0; num_samples = 0; stub_sel = 0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_samples", samples, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_sum_ed", sed_val(), 0);

        pin_lfsr_run();

        abort = 1; repeat (3) @(negedge clk); abort = 0;
        chk("abort_in_done_ignored", done, 1);

        run(0, 0, 1, 511, 5, -1, cyc);
        chk("lsb_samples", samples, 512);
        chk("lsb_err", err_count, 128);
        chk("lsb_sum_abs", sum_abs_ed, 128);
        chk("lsb_sum_ed", sed_val(), 128);
        chk("lsb_max", max_ed, 1);

        run(0, 123, 2, 511, -1, -1, cyc);
        chk("zero_err", err_count, 255);
        chk("zero_sum_abs", sum_abs_ed, 32640);
        chk("zero_sum_ed", sed_val(), 32640);
        chk("zero_max", max_ed, 255);

        run(0, 0, 0, 10, -1, -1, cyc);
        chk("abort10_samples", samples, 11);
        chk("abort10_err", err_count, 0);
        chk("abort10_cycles", cyc, 11 * (S + 2));

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 200);
            run(1, n, 4, ($urandom % 2) ? int'($urandom_range(0, n - 1)) : -1, $urandom_range(0, 3), -1, cyc);
        end
        run(0, 7, 4, 300, -1, -1, cyc);

        run(0, 0, 4, -1, -1, 50, cyc);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_samples", samples, 0);
        chk("rst_mid_sum_abs", sum_abs_ed, 0);

        pin_lfsr_run();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
